// File: rtl/down_count_checker.sv
`default_nettype none
// ============================================================================
// Module   : down_count_checker
// Purpose  : Tracks an upstream down counter, locks onto a correct sequence,
//            and counts step errors; wrap reporting under DCHK_WRAP_PULSE_EN.
// Revision : 1.0  initial release
// ============================================================================
module down_count_checker #(
  parameter int WIDTH  = 4,
  parameter int CW     = 8,
  parameter int LOCK_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_vld,
  input  logic             clr,
  output logic             locked,
  output logic             err_sticky,
  output logic [CW-1:0]    err_cnt,
  output logic [CW-1:0]    wrap_cnt,
  output logic             wrap_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0] c_lock_n = 4'(LOCK_N);

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_run;
  logic             r_locked;
  logic             r_err_sticky;
  logic [CW-1:0]    r_err_cnt;

  logic [WIDTH-1:0] w_exp;
  logic             w_hold;
  logic             w_step_ok;
  logic [3:0]       w_run_inc;

  // Modular subtraction makes 0 expect the all-ones value.
  assign w_exp     = r_prev - 1'b1;
  assign w_hold    = (cnt_in == r_prev);
  assign w_step_ok = (cnt_in == w_exp);
  assign w_run_inc = r_run + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else if (clr) begin
      r_state      <= IDLE;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else if (cnt_vld) begin
      case (r_state)
        IDLE: begin
          r_prev  <= cnt_in;
          r_run   <= '0;
          r_state <= ACQ;
        end
        ACQ: begin
          if (!w_hold) begin
            r_prev <= cnt_in;
            if (w_step_ok) begin
              r_run <= w_run_inc;
              if (w_run_inc == c_lock_n) begin
                r_state  <= LOCK;
                r_locked <= 1'b1;
              end
            end else begin
              r_run <= '0;
            end
          end
        end
        LOCK: begin
          if (!w_hold) begin
            r_prev <= cnt_in;
            if (!w_step_ok) begin
              r_run        <= '0;
              r_state      <= ACQ;
              r_locked     <= 1'b0;
              r_err_sticky <= 1'b1;
              if (r_err_cnt != {CW{1'b1}})
                r_err_cnt <= r_err_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign locked     = r_locked;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;

`ifdef DCHK_WRAP_PULSE_EN
  logic          r_wrap_pulse;
  logic [CW-1:0] r_wrap_cnt;
  logic          w_wrap;

  // A wrap only counts as a correct step from 0, and only once tracking has begun.
  assign w_wrap = cnt_vld && ((r_state == ACQ) || (r_state == LOCK)) &&
                  (r_prev == '0) && w_step_ok;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_wrap_pulse <= 1'b0;
      r_wrap_cnt   <= '0;
    end else begin
      r_wrap_pulse <= w_wrap;
      if (w_wrap && (r_wrap_cnt != {CW{1'b1}}))
        r_wrap_cnt <= r_wrap_cnt + 1'b1;
    end
  end

  assign wrap_pulse = r_wrap_pulse;
  assign wrap_cnt   = r_wrap_cnt;
`else
  assign wrap_pulse = 1'b0;
  assign wrap_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_down_count_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_down_count_checker
// Purpose  : Directed self-checking bench for down_count_checker.
// Revision : 1.0  initial release
// ============================================================================
module tb_down_count_checker;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       cnt_vld;
  logic       clr;
  logic       locked;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic [7:0] wrap_cnt;
  logic       wrap_pulse;

  int errors = 0;
  int checks = 0;

`ifdef DCHK_WRAP_PULSE_EN
  localparam logic c_wrap_en = 1'b1;
`else
  localparam logic c_wrap_en = 1'b0;
`endif

  down_count_checker #(.WIDTH(4), .CW(8), .LOCK_N(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_vld    (cnt_vld),
    .clr        (clr),
    .locked     (locked),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .wrap_cnt   (wrap_cnt),
    .wrap_pulse (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs mid-cycle, then return 1 time unit after the capturing edge.
  task automatic drive(input logic vld, input logic [3:0] v, input logic c);
    @(negedge clk);
    cnt_vld = vld;
    cnt_in  = v;
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b1, 4'd7, 1'b0);
    drive(1'b0, 4'd0, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b want=0", locked); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%0b want=0", err_sticky); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap_cnt got=%0d want=0", wrap_cnt); end
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap_pulse got=%0b want=0", wrap_pulse); end
    rst = 1'b1;
  endtask

  task automatic test_lock;
    logic [3:0] seq [4] = '{4'd15, 4'd14, 4'd13, 4'd12};
    logic       exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i], 1'b0);
      checks++;
      if (locked !== exp[i]) begin
        errors++; $display("FAIL lock_seq[%0d] locked got=%0b want=%0b", i, locked, exp[i]);
      end
    end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL lock_err_cnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_error;
    drive(1'b0, 4'd0, 1'b1);
    drive(1'b1, 4'd5, 1'b0);
    drive(1'b1, 4'd4, 1'b0);
    drive(1'b1, 4'd3, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_prelock got=%0b want=1", locked); end
    drive(1'b1, 4'd2, 1'b0);
    drive(1'b1, 4'd7, 1'b0);
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt got=%0d want=1", err_cnt); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b want=1", err_sticky); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_unlock got=%0b want=0", locked); end
    drive(1'b1, 4'd6, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_reacq1 got=%0b want=0", locked); end
    drive(1'b1, 4'd5, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_relock got=%0b want=1", locked); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_sticky_hold got=%0b want=1", err_sticky); end
  endtask

  task automatic test_wrap;
    for (int v = 4; v >= 0; v--) drive(1'b1, 4'(v), 1'b0);
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL wrap_pre_pulse got=%0b want=0", wrap_pulse); end
    drive(1'b1, 4'd15, 1'b0);
    checks++; if (wrap_pulse !== c_wrap_en) begin errors++; $display("FAIL wrap_pulse got=%0b want=%0b", wrap_pulse, c_wrap_en); end
    checks++; if (wrap_cnt !== {7'd0, c_wrap_en}) begin errors++; $display("FAIL wrap_cnt got=%0d want=%0d", wrap_cnt, c_wrap_en); end
    drive(1'b1, 4'd14, 1'b0);
    checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL wrap_pulse_width got=%0b want=0", wrap_pulse); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got=%0b want=1", locked); end
  endtask

  task automatic test_hold;
    for (int v = 13; v >= 9; v--) drive(1'b1, 4'(v), 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd9, 1'b0);
      checks++;
      if (locked !== 1'b1 || err_cnt !== 8'd1) begin
        errors++; $display("FAIL hold[%0d] locked=%0b err_cnt=%0d want locked=1 err_cnt=1", i, locked, err_cnt);
      end
    end
    drive(1'b0, 4'd3, 1'b0);
    drive(1'b0, 4'd3, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL gap locked=%0b err_cnt=%0d want locked=1 err_cnt=1", locked, err_cnt);
    end
    drive(1'b1, 4'd8, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL hold_step locked=%0b err_cnt=%0d want locked=1 err_cnt=1", locked, err_cnt);
    end
  endtask

  task automatic test_clr;
    drive(1'b1, 4'd2, 1'b1);
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL clr_sticky got=%0b want=0", err_sticky); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clr_locked got=%0b want=0", locked); end
    checks++; if (wrap_cnt !== 8'd0 || wrap_pulse !== 1'b0) begin
      errors++; $display("FAIL clr_wrap wrap_cnt=%0d wrap_pulse=%0b want 0,0", wrap_cnt, wrap_pulse);
    end
    // 7 follows the old prev of 8; only an IDLE checker ignores it as a step.
    drive(1'b1, 4'd7, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clr_idle got=%0b want=0", locked); end
    drive(1'b1, 4'd6, 1'b0);
    drive(1'b1, 4'd5, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_relock got=%0b want=1", locked); end
  endtask

  task automatic test_saturation;
    logic [3:0] v = 4'd5;
    for (int i = 0; i < 300; i++) begin
      v = v + 4'd5;
      drive(1'b1, v, 1'b0);
      v = v - 4'd1;
      drive(1'b1, v, 1'b0);
      v = v - 4'd1;
      drive(1'b1, v, 1'b0);
      if (i == 9) begin
        checks++; if (err_cnt !== 8'd10) begin errors++; $display("FAIL sat_mid got=%0d want=10", err_cnt); end
      end
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt got=%0d want=255", err_cnt); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got=%0b want=1", locked); end
    rst = 1'b0;
    drive(1'b1, v + 4'd7, 1'b1);
    rst = 1'b1;
    checks++;
    if (locked !== 1'b0 || err_sticky !== 1'b0 || err_cnt !== 8'd0 || wrap_cnt !== 8'd0 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset locked=%0b sticky=%0b err_cnt=%0d wrap_cnt=%0d pulse=%0b want all 0",
               locked, err_sticky, err_cnt, wrap_cnt, wrap_pulse);
    end
    drive(1'b1, 4'd3, 1'b0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%0b want=0", locked); end
  endtask

  initial begin
    rst     = 1'b0;
    cnt_in  = '0;
    cnt_vld = 1'b0;
    clr     = 1'b0;
    test_reset();
    test_lock();
    test_error();
    test_wrap();
    test_hold();
    test_clr();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
